serial_word_packer: RTL
=======================

# serial_word_packer

Upstream feeder for `one_detector`. It packs a serial bit stream (one bit per accepted beat) into WIDTH-bit words and presents each completed or flushed word on a valid/ready output whose `m_word` drives the detector's 64-bit `in`. The block holds one output word plus one in-progress/held accumulator, so input accepts the next word while the detector side stalls.

## Interface
- `WIDTH`, 64, output word width (≥2).
- `MSB_FIRST`, 1, 1: first bit lands in bit WIDTH-1; 0: first bit lands in bit 0.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset: one clock; reset is asynchronous and active-low.
- `s_valid`  input  1  input bit valid.
- `s_ready`  output  1  block accepts input bit.
- `s_bit`  input  1  serial data bit.
- `s_last`  input  1  accepted bit is the final bit of the current word (flush partial word).
- `m_valid`  output  1  output word valid.
- `m_ready`  input  1  downstream accepts word.
- `m_word`  output  WIDTH  packed word; unfilled positions zero.
- `m_count`  output  CW=$clog2(WIDTH+1)  number of real bits in `m_word`, 1..WIDTH.

## Operation
- A beat is accepted when `s_valid && s_ready`; an output handshake occurs when `m_valid && m_ready`.
- FSM states: FILL, HOLD. `s_ready = (state == FILL)`; it is registered-state only, with no combinational path from `m_ready`.
- FILL: each accepted bit is written into the accumulator at position `cnt` (MSB_FIRST: WIDTH-1-cnt), and `cnt` increments.
- Completing beat: an accepted bit with `cnt == WIDTH-1`, or with `s_last = 1`.
  - If the output slot is empty or handshakes this cycle, the completed word and count load into `m_word`/`m_count` and `m_valid` is 1 next cycle. The accumulator and `cnt` clear, and the state stays FILL.
  - Otherwise the completed word is held in the accumulator and the state goes to HOLD.
- HOLD: `s_ready = 0`. On an output handshake, the accumulator moves into the output register in the same edge, `m_valid` stays 1, the accumulator clears, and the state returns to FILL.
- Partial words (`s_last` before WIDTH bits): MSB_FIRST fills the top `m_count` bits; LSB_FIRST fills the bottom bits. Remaining bits are 0.
- `s_bit`/`s_last` are ignored when not accepted. `m_word`/`m_count` are stable while `m_valid && !m_ready`.
- Reset mid-word or in HOLD: the partial or held data is discarded with no flush.

## Timing
- Reset values: `m_valid = 0`, `m_word = 0`, `m_count = 0`, state FILL (`s_ready = 1`), accumulator and `cnt` = 0. Beats presented during reset are not accepted into state.
- Latency: completing beat accepted at edge N gives `m_valid = 1` in the cycle after edge N when the slot is free.
- Throughput: one bit per cycle sustained. Word boundaries add no bubble when `m_ready = 1`.
- Simultaneous output handshake and completing beat: the new word replaces the old one in the same edge, `m_valid` stays 1, and no bubble occurs.
- HOLD exit: `s_ready` returns to 1 the cycle after the releasing handshake.
- Wrap-around: `cnt` is CW bits wide and never exceeds WIDTH-1 in FILL. It clears on every completion.

## Structure
- Package `serial_pack_pkg`: state enum `{FILL, HOLD}` and a count-width localparam/function CW(WIDTH).
- Single module; no sub-module needed. Accumulator, output register and FSM are in one file.

## Test plan
- Reset: assert `rst_n = 0` after 10 accepted bits. Required: `m_valid = 0`, `m_word = 0`, `m_count = 0`, `s_ready = 1`. Next 64 zero bits yield `m_word = 0`, `m_count = 64`; no residue.
- Single one, MSB_FIRST: 64 bits with only the 14th bit (index 13) = 1 and `m_ready = 1`. Required: `m_word = 64'h0004_0000_0000_0000`, `m_count = 64`, `m_valid` one cycle after the 64th beat.
- Flush: bits 1,0,1 with `s_last` on the third bit. Required: `m_word = 64'hA000_0000_0000_0000`, `m_count = 3`. With `MSB_FIRST = 0`: `m_word = 64'h5`, `m_count = 3`.
- Backpressure: `m_ready = 0`, stream 128 bits (word A all ones, word B all zeros).
  - Required: A held stable, `s_ready = 0` after B completes.
  - Raising `m_ready` gives the A handshake, then B valid the next cycle, and `s_ready = 1` one cycle after the release.
- Continuous stream, `m_ready = 1`, 4 words of alternating `64'hAAAA…`/`64'h5555…`. Required: every word is correct, `s_ready` never drops, and completion and handshake coincide with no bubble.
- Random `s_valid`/`m_ready` with random `s_last`. The scoreboard compares words and counts against a reference packer, with no loss or duplication.

Source files
------------

// File: rtl/serial_pack_pkg.sv
// -----------------------------------------------------------------------------
// serial_pack_pkg
// Shared definitions for serial_word_packer.
//   state_e : packer FSM states (FILL accepts bits, HOLD parks a completed
//             word while the output slot is still occupied).
//   cw_of   : width of the bit counter / m_count for a given word width,
//             wide enough to represent WIDTH itself.
// -----------------------------------------------------------------------------
package serial_pack_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic int cw_of(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_packer.sv
// -----------------------------------------------------------------------------
// serial_word_packer
// Packs a serial bit stream into WIDTH-bit words. It has one accumulator and one
// output register. The input side can therefore build, and park, the next word
// while the output is stalled.
//
// Parameters
//   WIDTH      output word width (>= 2)
//   MSB_FIRST  1: first bit of a word lands in bit WIDTH-1; 0: in bit 0
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   s_valid  input bit valid
//   s_ready  packer accepts an input bit (registered state only)
//   s_bit    serial data bit
//   s_last   accepted bit ends the current word (flushes a partial word)
//   m_valid  output word valid
//   m_ready  downstream accepts the word
//   m_word   packed word, unfilled positions zero
//   m_count  number of real bits in m_word (1..WIDTH)
// -----------------------------------------------------------------------------
module serial_word_packer
    import serial_pack_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_bit,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_word,
    output logic [CW-1:0]    m_count
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             m_hs;
    logic             complete;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] acc_wr;
    logic [CW-1:0]    cnt_inc;

    assign s_ready = (state_q == FILL);
    assign m_valid = valid_q;
    assign m_word  = word_q;
    assign m_count = count_q;

    assign accept   = s_valid && s_ready;
    assign m_hs     = valid_q && m_ready;
    assign cnt_inc  = cnt_q + CW'(1);
    assign complete = accept && (s_last || (cnt_q == CW'(WIDTH - 1)));

    // One-hot write position derived by shifting a single set bit. This avoids
    // indexing the word with a count wider than the bit index.
    always_comb begin
        if (MSB_FIRST) begin
            bit_mask = {1'b1, {(WIDTH-1){1'b0}}} >> cnt_q;
        end else begin
            bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << cnt_q;
        end
        // The accumulator is all zeros beyond cnt, so OR-ing in the bit is enough.
        acc_wr = s_bit ? (acc_q | bit_mask) : acc_q;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        count_d = count_q;
        valid_d = valid_q && !m_hs;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (complete && (!valid_q || m_hs)) begin
                        // The output slot is free, or frees on this edge.
                        // The new word goes straight out with no bubble.
                        word_d  = acc_wr;
                        count_d = cnt_inc;
                        valid_d = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else if (complete) begin
                        // The slot is occupied. Park the finished word. In HOLD,
                        // cnt carries its bit count, which may equal WIDTH.
                        acc_d   = acc_wr;
                        cnt_d   = cnt_inc;
                        state_d = HOLD;
                    end else begin
                        acc_d = acc_wr;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HOLD: begin
                if (m_hs) begin
                    word_d  = acc_q;
                    count_d = cnt_q;
                    valid_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

endmodule
